sprite_engine_n: RTL and testbench

SPRITE_ENGINE_N -- requirements
Module: tqvp_sprite_engine_n

---
 rtl/sprite_engine_pkg.sv | 18 +
 rtl/sprite_engine_n_timing.sv | 42 ++++
 rtl/sprite_engine_n.sv | 125 ++++++++++++
 tb/tb_sprite_engine_n.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_engine_pkg.sv
// sprite_engine_pkg: register map, control/status bit indices and the fixed sprite palette
package sprite_engine_pkg;
  localparam logic [5:0] A_CTRL = 6'h00;
  localparam logic [5:0] A_STAT = 6'h01;
  localparam logic [5:0] A_SEL  = 6'h02;
  localparam logic [5:0] A_POS  = 6'h04;
  localparam logic [5:0] A_ATTR = 6'h06;
  localparam logic [5:0] A_PTR  = 6'h08;
  localparam logic [5:0] A_BMP  = 6'h0A;
  localparam int C_STREAM = 0;
  localparam int C_VSIE   = 1;
  localparam int C_COLIE  = 2;
  localparam int S_VS     = 0;
  localparam int S_COLL   = 1;
  function automatic logic [5:0] pal_rgb(input logic [1:0] p);
    return p == 2'd0 ? 6'b00_00_11 : p == 2'd1 ? 6'b00_11_00 : p == 2'd2 ? 6'b11_00_00 : 6'b11_11_11;
  endfunction
endpackage

// File: rtl/sprite_engine_n_timing.sv
// tqvp_vga_timing: h/v raster counters held at 0 while disabled, active-low syncs and frame marker
module tqvp_vga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [11:0] o_h,
  output logic [11:0] o_v,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_vis,
  output logic        o_vs_start
);
  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int VS0 = V_ACTIVE + V_FP;
  logic [11:0] r_h, r_v;
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= r_h == 12'(HT - 1) ? 12'd0 : r_h + 12'd1;
      if (r_h == 12'(HT - 1)) r_v <= r_v == 12'(VT - 1) ? 12'd0 : r_v + 12'd1;
    end
  end
  assign o_h        = r_h;
  assign o_v        = r_v;
  assign o_hs       = !(r_h >= 12'(HS0) && r_h < 12'(HS0 + H_SYNC));
  assign o_vs       = !(r_v >= 12'(VS0) && r_v < 12'(VS0 + V_SYNC));
  assign o_vis      = r_h < 12'(H_ACTIVE) && r_v < 12'(V_ACTIVE);
  assign o_vs_start = r_h == 12'd0 && r_v == 12'(VS0);
endmodule

// File: rtl/sprite_engine_n.sv
// sprite_engine_n: register-programmed VGA sprite overlay on TinyVGA pins
// Define SPR_COLLISION_EN to add detection of overlapping opaque sprite pixels.
module sprite_engine_n
  import sprite_engine_pkg::*;
#(
  parameter int NUM_SPR  = 4,
  parameter int SPR_DIM  = 12,
  parameter int SCALE_SH = 2,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  logic [2:0]  r_ctrl, r_sel;
  logic [1:0]  r_stat;
  logic [3:0]  r_ptr;
  logic [15:0] r_spos [8];
  logic [15:0] r_apos [8];
  logic [3:0]  r_sattr [8];
  logic [3:0]  r_aattr [8];
  logic [15:0] r_bmp [8][16];
  logic [7:0]  r_uo;
  logic [11:0] w_h, w_v;
  logic [8:0]  w_lx, w_ly;
  logic [NUM_SPR-1:0] w_hit;
  logic [5:0]  w_rgb;
  logic w_hs, w_vs, w_vis, w_frame, w_we, w_sel_ok, w_row_ok, w_coll, w_unused;
  assign w_unused = &{1'b0, ui_in, data_read_n, data_in[31:16]};
  assign w_we     = data_write_n != 2'b11;
  assign w_sel_ok = 32'(r_sel) < NUM_SPR;
  assign w_row_ok = 32'(r_ptr) < SPR_DIM;
  assign w_lx     = 9'(w_h >> SCALE_SH);
  assign w_ly     = 9'(w_v >> SCALE_SH);
  tqvp_vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tim (
    .clk(clk), .rst(rst), .i_en(r_ctrl[C_STREAM]), .o_h(w_h), .o_v(w_v),
    .o_hs(w_hs), .o_vs(w_vs), .o_vis(w_vis), .o_vs_start(w_frame)
  );
  // Offsets are 9 bits wide so sprites clip at the right/bottom edge instead of wrapping
  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    logic [8:0] w_dx, w_dy;
    logic [3:0] w_c;
    assign w_dx = w_lx - {1'b0, r_apos[i][7:0]};
    assign w_dy = w_ly - {1'b0, r_apos[i][15:8]};
    assign w_c  = r_aattr[i][2] ? 4'(SPR_DIM - 1) - w_dx[3:0] : w_dx[3:0];
    assign w_hit[i] = w_vis && r_aattr[i][3] && w_lx >= {1'b0, r_apos[i][7:0]} &&
                      w_ly >= {1'b0, r_apos[i][15:8]} && w_dx < 9'(SPR_DIM) &&
                      w_dy < 9'(SPR_DIM) && r_bmp[i][w_dy[3:0]][w_c];
  end
  always_comb begin
    w_rgb = 6'd0;
    for (int k = 0; k < NUM_SPR; k++) w_rgb = w_hit[k] ? pal_rgb(r_aattr[k][1:0]) : w_rgb;
  end
`ifdef SPR_COLLISION_EN
  assign w_coll = |(w_hit & (w_hit - NUM_SPR'(1)));
`else
  assign w_coll = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_stat <= '0;
      r_sel  <= '0;
      r_ptr  <= '0;
      r_uo   <= '0;
      for (int k = 0; k < 8; k++) begin
        r_spos[k]  <= '0;
        r_apos[k]  <= '0;
        r_sattr[k] <= '0;
        r_aattr[k] <= '0;
        for (int j = 0; j < 16; j++) r_bmp[k][j] <= '0;
      end
    end else begin
      if (w_we && address == A_CTRL) r_ctrl <= data_in[2:0];
      if (w_we && address == A_SEL) r_sel <= data_in[2:0];
      if (w_we && address == A_POS && w_sel_ok) r_spos[r_sel] <= data_in[15:0];
      if (w_we && address == A_ATTR && w_sel_ok) r_sattr[r_sel] <= data_in[3:0];
      if (w_we && address == A_PTR) r_ptr <= data_in[3:0];
      else if (w_we && address == A_BMP && w_sel_ok) r_ptr <= r_ptr == 4'(SPR_DIM - 1) ? 4'd0 : r_ptr + 4'd1;
      if (w_we && address == A_BMP && w_sel_ok && w_row_ok) r_bmp[r_sel][r_ptr] <= 16'(data_in[SPR_DIM-1:0]);
      r_stat[S_VS]   <= w_frame | (r_stat[S_VS] & !(w_we && address == A_STAT && data_in[S_VS]));
      r_stat[S_COLL] <= w_coll | (r_stat[S_COLL] & !(w_we && address == A_STAT && data_in[S_COLL]));
      // Shadow copies land at vsync start so a frame never shows a half-updated layout
      if (!r_ctrl[C_STREAM] || w_frame) begin
        r_apos  <= r_spos;
        r_aattr <= r_sattr;
      end
      r_uo <= r_ctrl[C_STREAM] ? {w_hs, w_rgb[0], w_rgb[2], w_rgb[4], w_vs, w_rgb[1], w_rgb[3], w_rgb[5]} : 8'd0;
    end
  end
  always_comb begin
    data_out = 32'd0;
    case (address)
      A_CTRL:  data_out = {29'd0, r_ctrl};
      A_STAT:  data_out = {30'd0, r_stat};
      A_SEL:   data_out = {29'd0, r_sel};
      A_POS:   data_out = w_sel_ok ? {16'd0, r_spos[r_sel]} : 32'd0;
      A_ATTR:  data_out = w_sel_ok ? {28'd0, r_sattr[r_sel]} : 32'd0;
      A_PTR:   data_out = {28'd0, r_ptr};
      A_BMP:   data_out = w_sel_ok && w_row_ok ? {16'd0, r_bmp[r_sel][r_ptr]} : 32'd0;
      default: data_out = 32'd0;
    endcase
  end
  assign uo_out         = r_uo;
  assign data_ready     = 1'b1;
  assign user_interrupt = (r_stat[S_VS] & r_ctrl[C_VSIE]) | (r_stat[S_COLL] & r_ctrl[C_COLIE]);
endmodule

// File: tb/tb_sprite_engine_n.sv
// tb_sprite_engine_n: directed scoreboard bench for sprite_engine_n on a shrunken 80x56 raster
module tb_sprite_engine_n;
  localparam logic [5:0] RED = 6'b11_00_00;
  localparam logic [5:0] GRN = 6'b00_11_00;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ui_in = 8'd0;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'd0;
  logic [31:0] data_in = 32'd0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready, user_interrupt;
  logic [31:0] q[$];
  int n_asrt = 0;
  int n_fail = 0;
  int m_h = 0;
  int m_v = 0;
  bit m_en = 1'b0;
  always #5 clk = ~clk;
  sprite_engine_n #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(3), .V_BP(3)
  ) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );
  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = 32'hDEAD_BEEF;
    if (q.size() > 0) e = q.pop_front();
    n_asrt++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask
  task automatic expect_sig(input string tag, input logic [31:0] obs, input logic [31:0] e);
    q.push_back(e);
    chk(tag, obs);
  endtask
  task automatic tick();
    @(negedge clk);
    if (!m_en) begin
      m_h = 0;
      m_v = 0;
    end else if (m_h == 79) begin
      m_h = 0;
      m_v = (m_v == 55) ? 0 : m_v + 1;
    end else m_h++;
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn = 2'b00);
    address = a;
    data_in = d;
    data_write_n = wn;
    tick();
    data_write_n = 2'b11;
    if (a == 6'h00) m_en = d[0];
  endtask
  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string tag);
    address = a;
    #1;
    expect_sig(tag, data_out, e);
  endtask
  function automatic logic [7:0] px(input int h, input int v, input logic [5:0] c);
    logic hs, vs;
    logic [5:0] k;
    hs = !(h >= 68 && h < 76);
    vs = !(v >= 50 && v < 53);
    k = (h < 64 && v < 48) ? c : 6'd0;
    return {hs, k[0], k[2], k[4], vs, k[1], k[3], k[5]};
  endfunction
  task automatic chk_px(input logic [5:0] c);
    string tag;
    tag = $sformatf("pixel h%0d v%0d", m_h, m_v);
    q.push_back(32'(px(m_h, m_v, c)));
    tick();
    chk(tag, 32'(uo_out));
  endtask
  task automatic wait_pos(input int v, input int h);
    for (int n = 0; n < 20000 && !(m_v == v && m_h == h); n++) tick();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a <= 10; a++) rd(6'(a), 32'd0, $sformatf("reset_reg%0d", a));
    expect_sig("reset_uo", 32'(uo_out), 32'd0);
    expect_sig("reset_irq", 32'(user_interrupt), 32'd0);
    expect_sig("data_ready", 32'(data_ready), 32'd1);
    wr(6'h02, 32'd1);
    wr(6'h08, 32'd0);
    for (int r = 0; r < 12; r++) wr(6'h0A, 32'h0FFF, 2'(r % 3));
    rd(6'h08, 32'd0, "ptr_wrap12");
    rd(6'h0A, 32'h0FFF, "bmp_row0");
    wr(6'h08, 32'd5);
    wr(6'h0A, 32'hFFFF_F555);
    rd(6'h08, 32'd6, "ptr_inc");
    wr(6'h08, 32'd5);
    rd(6'h0A, 32'h0555, "bmp_mask");
    wr(6'h08, 32'd11);
    wr(6'h0A, 32'h0FFF);
    rd(6'h08, 32'd0, "ptr_wrap11");
    wr(6'h02, 32'd5);
    wr(6'h04, 32'h1234);
    rd(6'h04, 32'd0, "sel_oob_pos");
    rd(6'h06, 32'd0, "sel_oob_attr");
    rd(6'h0A, 32'd0, "sel_oob_bmp");
    wr(6'h02, 32'd1);
    rd(6'h04, 32'd0, "sel1_pos");
    wr(6'h02, 32'd0);
    wr(6'h04, 32'h0000);
    wr(6'h06, 32'hA);
    rd(6'h06, 32'hA, "attr_rb");
    wr(6'h08, 32'd0);
    wr(6'h0A, 32'h001);
    wr(6'h00, 32'd1);
    for (int k = 0; k < 8; k++) chk_px(m_h < 4 ? RED : 6'd0);
    wr(6'h00, 32'd0);
    tick();
    expect_sig("uo_stopped", 32'(uo_out), 32'd0);
    wr(6'h06, 32'hE);
    wr(6'h00, 32'd1);
    for (int k = 0; k < 50; k++) chk_px((m_h >= 44 && m_h < 48) ? RED : 6'd0);
    wr(6'h00, 32'd0);
    wr(6'h06, 32'hA);
    wr(6'h02, 32'd3);
    wr(6'h04, 32'h0000);
    wr(6'h06, 32'h9);
    wr(6'h08, 32'd0);
    wr(6'h0A, 32'h001);
    wr(6'h00, 32'd5);
    for (int k = 0; k < 5; k++) chk_px(m_h < 4 ? GRN : 6'd0);
`ifdef SPR_COLLISION_EN
    rd(6'h01, 32'd2, "coll_status");
    expect_sig("coll_irq", 32'(user_interrupt), 32'd1);
`else
    rd(6'h01, 32'd0, "coll_status");
    expect_sig("coll_irq", 32'(user_interrupt), 32'd0);
`endif
    wr(6'h00, 32'd0);
    wr(6'h06, 32'h1);
    wr(6'h02, 32'd0);
    wr(6'h01, 32'd3);
    wr(6'h00, 32'd1);
    wait_pos(1, 10);
    wr(6'h04, 32'h0002);
    wait_pos(2, 0);
    for (int k = 0; k < 12; k++) chk_px(m_h < 4 ? RED : 6'd0);
    wait_pos(0, 0);
    for (int k = 0; k < 12; k++) chk_px((m_h >= 8 && m_h < 12) ? RED : 6'd0);
    wr(6'h01, 32'd3);
    wr(6'h00, 32'd3);
    expect_sig("vs_irq_idle", 32'(user_interrupt), 32'd0);
    wait_pos(50, 0);
    expect_sig("vs_irq_before", 32'(user_interrupt), 32'd0);
    chk_px(6'd0);
    expect_sig("vs_irq_set", 32'(user_interrupt), 32'd1);
    rd(6'h01, 32'd1, "vs_status");
    wr(6'h01, 32'd1);
    expect_sig("vs_irq_clr", 32'(user_interrupt), 32'd0);
    rd(6'h01, 32'd0, "vs_status_clr");
    wait_pos(50, 0);
    chk_px(6'd0);
    expect_sig("vs_irq_again", 32'(user_interrupt), 32'd1);
    rst = 1'b1;
    tick();
    expect_sig("midrst_uo", 32'(uo_out), 32'd0);
    expect_sig("midrst_irq", 32'(user_interrupt), 32'd0);
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
